pipe_stage_reg: RTL

//  Generic Y86 inter-stage pipeline register (F->D, D->E, E->M, M->W). Carries stat, icode,

---
 rtl/y86_pipe_pkg.sv | 41 ++++
 rtl/pipe_perf_cnt.sv | 20 ++
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 3 files changed

// File: rtl/y86_pipe_pkg.sv
// Shared Y86 pipeline definitions: instruction codes, status codes,
// register ids and the per-stage instruction field bundle.
package y86_pipe_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'h1;
    localparam logic [2:0] SADR = 3'h2;
    localparam logic [2:0] SINS = 3'h3;
    localparam logic [2:0] SHLT = 3'h4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] rA;
        logic [3:0] rB;
    } stage_fld_t;

    function automatic stage_fld_t nop_fld(input logic [3:0] icode);
        stage_fld_t f;
        f.icode = icode;
        f.ifun  = 4'h0;
        f.rA    = RNONE;
        f.rB    = RNONE;
        return f;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with synchronous active-low reset and clear.
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic Y86 inter-stage pipeline register with stall/bubble control.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import y86_pipe_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter int                NUM_VAL     = 2,
    parameter int                STAT_W      = 3,
    parameter logic [3:0]        NOP_ICODE   = INOP,
    parameter logic [STAT_W-1:0] BUBBLE_STAT = STAT_W'(SAOK)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      bubble,
    input  logic [STAT_W-1:0]         in_stat,
    input  logic [3:0]                in_icode,
    input  logic [3:0]                in_ifun,
    input  logic [3:0]                in_rA,
    input  logic [3:0]                in_rB,
    input  logic [NUM_VAL*DATA_W-1:0] in_val,
    output logic [STAT_W-1:0]         out_stat,
    output logic [3:0]                out_icode,
    output logic [3:0]                out_ifun,
    output logic [3:0]                out_rA,
    output logic [3:0]                out_rB,
    output logic [NUM_VAL*DATA_W-1:0] out_val,
    output logic                      out_valid,
    output logic                      ctl_err
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               bubble_cnt
`endif
);

    localparam int VW = NUM_VAL * DATA_W;

    typedef enum logic {
        ST_BUBBLE = 1'b0,
        ST_VALID  = 1'b1
    } vstate_t;

    vstate_t           state;
    stage_fld_t        fld;
    logic [STAT_W-1:0] stat_q;
    logic [VW-1:0]     val_q;
    logic              err_q;

    logic do_hold;
    logic do_bub;
    logic do_load;

    // Stall dominates bubble, so the three actions are mutually exclusive.
    assign do_hold = stall;
    assign do_bub  = bubble & ~stall;
    assign do_load = ~stall & ~bubble;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_BUBBLE;
            fld    <= nop_fld(NOP_ICODE);
            stat_q <= BUBBLE_STAT;
            val_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (stall && bubble) begin
                err_q <= 1'b1;
            end
            unique case (1'b1)
                do_hold: begin
                end
                do_bub: begin
                    state  <= ST_BUBBLE;
                    fld    <= nop_fld(NOP_ICODE);
                    stat_q <= BUBBLE_STAT;
                    val_q  <= '0;
                end
                do_load: begin
                    state     <= ST_VALID;
                    fld.icode <= in_icode;
                    fld.ifun  <= in_ifun;
                    fld.rA    <= in_rA;
                    fld.rB    <= in_rB;
                    stat_q    <= in_stat;
                    val_q     <= in_val;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_stat  = stat_q;
    assign out_icode = fld.icode;
    assign out_ifun  = fld.ifun;
    assign out_rA    = fld.rA;
    assign out_rB    = fld.rB;
    assign out_val   = val_q;
    assign out_valid = (state == ST_VALID);
    assign ctl_err   = err_q;

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (stall),
        .cnt   (stall_cnt)
    );

    pipe_perf_cnt #(.W(32)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (do_bub),
        .cnt   (bubble_cnt)
    );
`endif

endmodule
